// File: rtl/fr_xfer_if.sv
// Command handshake and file-register port bundle between the decoder/FR side
// and the transfer sequencer; the sequencer uses the slave view.
interface fr_xfer_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic          busy;
  logic          done;
  logic          FR_WE;
  logic [AW-1:0] FR_Waddr;
  logic [DW-1:0] FR_Wdata;
  logic [AW-1:0] FR_RAddr_1;
  logic [DW-1:0] FR_Rdata_1;
  logic [AW-1:0] FR_RAddr_2;
  logic [DW-1:0] FR_Rdata_2;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data,
    input  FR_Rdata_1, FR_Rdata_2,
    output cmd_ready, busy, done,
    output FR_WE, FR_Waddr, FR_Wdata, FR_RAddr_1, FR_RAddr_2
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data,
    output FR_Rdata_1, FR_Rdata_2,
    input  cmd_ready, busy, done,
    input  FR_WE, FR_Waddr, FR_Wdata, FR_RAddr_1, FR_RAddr_2
  );
endinterface

// File: rtl/fr_xfer_ctrl.sv
// File-register transfer sequencer: turns one MOVE/SWAP/FILL/NOP command at a
// time into a per-cycle stream of FR reads and writes.
module fr_xfer_ctrl #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic      clk,
  input  logic      rst,
  fr_xfer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SWAP_A,
    S_SWAP_B,
    S_FILL,
    S_NOP
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] rd2_reg, rd2_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          desc_reg, desc_next;
  logic [DW-1:0] data_reg, data_next;
  logic [DW-1:0] tmp_reg, tmp_next;
  logic [DW-1:0] wlast_reg, wlast_next;
  logic          done_reg, done_next;

  logic          we;
  logic [DW-1:0] wdata;
  logic [AW-1:0] gap;
  logic          overlap;
  logic [AW-1:0] step;

  // A destination that starts inside the source block would overwrite unread
  // source data when copying upward, so such moves run from the top down.
  assign gap     = bus.cmd_dst - bus.cmd_src;
  assign overlap = (gap != '0) && (gap <= bus.cmd_len);
  assign step    = desc_reg ? {AW{1'b1}} : AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      src_reg   <= '0;
      rd2_reg   <= '0;
      dst_reg   <= '0;
      cnt_reg   <= '0;
      desc_reg  <= 1'b0;
      data_reg  <= '0;
      tmp_reg   <= '0;
      wlast_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      rd2_reg   <= rd2_next;
      dst_reg   <= dst_next;
      cnt_reg   <= cnt_next;
      desc_reg  <= desc_next;
      data_reg  <= data_next;
      tmp_reg   <= tmp_next;
      wlast_reg <= wlast_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    rd2_next   = rd2_reg;
    dst_next   = dst_reg;
    cnt_next   = cnt_reg;
    desc_next  = desc_reg;
    data_next  = data_reg;
    tmp_next   = tmp_reg;
    wlast_next = wlast_reg;
    done_next  = 1'b0;
    we         = 1'b0;
    wdata      = wlast_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          data_next = bus.cmd_data;
          cnt_next  = bus.cmd_len;
          case (bus.cmd_op)
            2'b00: begin
              desc_next  = overlap;
              src_next   = overlap ? bus.cmd_src + bus.cmd_len : bus.cmd_src;
              dst_next   = overlap ? bus.cmd_dst + bus.cmd_len : bus.cmd_dst;
              state_next = S_MOVE;
            end
            2'b01: begin
              src_next   = bus.cmd_src;
              rd2_next   = bus.cmd_dst;
              dst_next   = bus.cmd_src;
              state_next = S_SWAP_A;
            end
            2'b10: begin
              desc_next  = 1'b0;
              dst_next   = bus.cmd_dst;
              state_next = S_FILL;
            end
            default: state_next = S_NOP;
          endcase
        end
      end
      S_MOVE: begin
        we    = 1'b1;
        wdata = bus.FR_Rdata_1;
        if (cnt_reg == '0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - AW'(1);
          src_next = src_reg + step;
          dst_next = dst_reg + step;
        end
      end
      S_SWAP_A: begin
        // B's old value is written to A now; A's old value waits in tmp.
        we         = 1'b1;
        wdata      = bus.FR_Rdata_2;
        tmp_next   = bus.FR_Rdata_1;
        dst_next   = rd2_reg;
        state_next = S_SWAP_B;
      end
      S_SWAP_B: begin
        we         = 1'b1;
        wdata      = tmp_reg;
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      S_FILL: begin
        we    = 1'b1;
        wdata = data_reg;
        if (cnt_reg == '0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - AW'(1);
          dst_next = dst_reg + AW'(1);
        end
      end
      S_NOP: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (we) begin
      wlast_next = wdata;
    end
  end

  assign bus.cmd_ready  = (state_reg == S_IDLE);
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.done       = done_reg;
  assign bus.FR_WE      = we;
  assign bus.FR_Waddr   = dst_reg;
  assign bus.FR_Wdata   = wdata;
  assign bus.FR_RAddr_1 = src_reg;
  assign bus.FR_RAddr_2 = rd2_reg;

endmodule

// File: tb/tb_fr_xfer_ctrl.sv
// Bench for fr_xfer_ctrl: a 32x8 FR model, directed commands, and a scoreboard
// of expected writes/done pulses checked by an independent monitor.
module tb_fr_xfer_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fr_xfer_if #(.AW(AW), .DW(DW)) bus ();

  fr_xfer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] fr [32];
  logic          fr_init = 1'b0;
  int            cyc = 0;
  bit            mon_on = 1'b0;

  always @(posedge clk) begin
    if (fr_init) begin
      for (int i = 0; i < 32; i++) fr[i] <= DW'(i);
    end else if (bus.FR_WE === 1'b1) begin
      fr[bus.FR_Waddr] <= bus.FR_Wdata;
    end
  end
  assign bus.FR_Rdata_1 = fr[bus.FR_RAddr_1];
  assign bus.FR_Rdata_2 = fr[bus.FR_RAddr_2];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         tag;
    bit            is_done;
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic push_wr(input string tag, input int c, input int a, input int d);
    ev_t e;
    e.tag = tag; e.is_done = 1'b0; e.cyc = c; e.addr = AW'(a); e.data = DW'(d);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input string tag, input int c);
    ev_t e;
    e.tag = tag; e.is_done = 1'b1; e.cyc = c; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every write or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.FR_WE !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h at cyc %0d, expected no event",
                   bus.FR_Waddr, bus.FR_Wdata, cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check({e.tag, "_kind_is_write"}, 32'(e.is_done), 32'(0));
          check({e.tag, "_wr_cycle"}, cyc, e.cyc);
          check({e.tag, "_wr_addr"}, 32'(bus.FR_Waddr), 32'(e.addr));
          check({e.tag, "_wr_data"}, 32'(bus.FR_Wdata), 32'(e.data));
        end
      end
      if (bus.done !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 at cyc %0d, expected no event", cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check({e.tag, "_kind_is_done"}, 32'(e.is_done), 32'(1));
          check({e.tag, "_done_cycle"}, cyc, e.cyc);
          check({e.tag, "_ready_with_done"}, 32'(bus.cmd_ready), 32'(1));
        end
      end
    end
  end

  task automatic init_fr();
    @(negedge clk) fr_init = 1'b1;
    @(negedge clk) fr_init = 1'b0;
  endtask

  // Present a command; tc is the cycle counter value in cycle T+1.
  task automatic issue(input logic [1:0] op, input int src, input int dst, input int len,
                       input int data, input bit hold, output int tc);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_src   = AW'(src);
    bus.cmd_dst   = AW'(dst);
    bus.cmd_len   = AW'(len);
    bus.cmd_data  = DW'(data);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1 tc = cyc;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain: got %0d events outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tc, tc2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b11;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (3) @(posedge clk);
    init_fr();
    @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_fr_we", 32'(bus.FR_WE), 32'(0));
    check("rst_waddr", 32'(bus.FR_Waddr), 32'(0));
    check("rst_wdata", 32'(bus.FR_Wdata), 32'(0));
    check("rst_raddr1", 32'(bus.FR_RAddr_1), 32'(0));
    check("rst_raddr2", 32'(bus.FR_RAddr_2), 32'(0));
    mon_on = 1'b1;

    // Plain ascending move.
    init_fr();
    issue(2'b00, 0, 8, 3, 0, 1'b0, tc);
    for (int k = 0; k < 4; k++) push_wr("move_asc", tc + k, 8 + k, k);
    push_done("move_asc", tc + 4);
    drain("move_asc");
    for (int k = 0; k < 4; k++) check($sformatf("move_asc_reg%0d", 8 + k), 32'(fr[8 + k]), 32'(k));
    check("move_asc_reg12", 32'(fr[12]), 32'(12));

    // Overlapping move runs descending.
    init_fr();
    issue(2'b00, 4, 6, 3, 0, 1'b0, tc);
    push_wr("move_desc", tc + 0, 9, 7);
    push_wr("move_desc", tc + 1, 8, 6);
    push_wr("move_desc", tc + 2, 7, 5);
    push_wr("move_desc", tc + 3, 6, 4);
    push_done("move_desc", tc + 4);
    drain("move_desc");
    for (int k = 0; k < 4; k++) check($sformatf("move_desc_reg%0d", 6 + k), 32'(fr[6 + k]), 32'(4 + k));
    check("move_desc_reg4", 32'(fr[4]), 32'(4));
    check("move_desc_reg5", 32'(fr[5]), 32'(5));

    // Swap of two registers, then a self-swap.
    init_fr();
    issue(2'b01, 2, 30, 0, 0, 1'b0, tc);
    push_wr("swap", tc, 2, 30);
    push_wr("swap", tc + 1, 30, 2);
    push_done("swap", tc + 2);
    drain("swap");
    check("swap_reg2", 32'(fr[2]), 32'(30));
    check("swap_reg30", 32'(fr[30]), 32'(2));
    issue(2'b01, 5, 5, 0, 0, 1'b0, tc);
    push_wr("swap_self", tc, 5, 5);
    push_wr("swap_self", tc + 1, 5, 5);
    push_done("swap_self", tc + 2);
    drain("swap_self");
    check("swap_self_reg5", 32'(fr[5]), 32'(5));

    // Fill wrapping past the top of the address space.
    init_fr();
    issue(2'b10, 0, 30, 3, 8'hAA, 1'b0, tc);
    push_wr("fill_wrap", tc + 0, 30, 8'hAA);
    push_wr("fill_wrap", tc + 1, 31, 8'hAA);
    push_wr("fill_wrap", tc + 2, 0, 8'hAA);
    push_wr("fill_wrap", tc + 3, 1, 8'hAA);
    push_done("fill_wrap", tc + 4);
    drain("fill_wrap");
    check("fill_reg30", 32'(fr[30]), 32'(8'hAA));
    check("fill_reg31", 32'(fr[31]), 32'(8'hAA));
    check("fill_reg0", 32'(fr[0]), 32'(8'hAA));
    check("fill_reg1", 32'(fr[1]), 32'(8'hAA));
    check("fill_reg2", 32'(fr[2]), 32'(2));

    // Reset during cycle T+2 of an 8-element move: two writes, no done.
    init_fr();
    issue(2'b00, 0, 16, 7, 0, 1'b0, tc);
    push_wr("abort", tc, 16, 0);
    push_wr("abort", tc + 1, 17, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_fr_we", 32'(bus.FR_WE), 32'(0));
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    check("abort_done", 32'(bus.done), 32'(0));
    drain("abort");
    check("abort_reg16", 32'(fr[16]), 32'(0));
    check("abort_reg17", 32'(fr[17]), 32'(1));
    check("abort_reg18", 32'(fr[18]), 32'(18));

    // NOP with cmd_valid held, FILL queued behind it.
    init_fr();
    issue(2'b11, 0, 0, 0, 0, 1'b1, tc);
    push_done("nop", tc + 1);
    issue(2'b10, 0, 12, 1, 8'h55, 1'b0, tc2);
    check("fill_accept_on_nop_done", tc2, tc + 2);
    push_wr("fill_b2b", tc2, 12, 8'h55);
    push_wr("fill_b2b", tc2 + 1, 13, 8'h55);
    push_done("fill_b2b", tc2 + 2);
    drain("fill_b2b");
    check("fill_b2b_reg12", 32'(fr[12]), 32'(8'h55));
    check("fill_b2b_reg13", 32'(fr[13]), 32'(8'h55));
    check("fill_b2b_reg14", 32'(fr[14]), 32'(14));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
